axi_lite_cbus_bridge: RTL and testbench
=======================================

# axi_lite_cbus_bridge

AXI4-Lite slave that converts host register accesses into single-cycle CBus read/write strobes for the peripheral register blocks (AXI2S, AD9361). It sits directly upstream of the CBus read-data merge stage. It drives the shared en/wen/addr/din bus and captures the merged registered read data after a fixed latency. One transaction is in flight at a time.

## Interface
- ADDR_W, 20: AXI byte-address width; CBus word address = addr[ADDR_W-1:2] (18 bits).
- RD_LAT, 1: cycles from the cbus_en cycle until cbus_dout is valid (1..7).
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awvalid / s_axi_awready  in / out  1  write address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid / s_axi_wready  in / out  1  write data handshake.
- s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- s_axi_bvalid / s_axi_bready  out / in  1  write response handshake.
- s_axi_araddr  in  ADDR_W  read address.
- s_axi_arvalid / s_axi_arready  in / out  1  read address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  always 00.
- s_axi_rvalid / s_axi_rready  out / in  1  read data handshake.
- cbus_en  out  1  access strobe, exactly one cycle per transaction.
- cbus_wen  out  1  1 = write, 0 = read; qualified by cbus_en.
- cbus_addr  out  18  CBus word address.
- cbus_din  out  32  write data.
- cbus_dout  in  32  merged read data.

## Operation
- States: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE, write eligible: awvalid & wvalid both high. Read eligible: arvalid high.
- Arbitration is round-robin on a last_was_write flag:
  - If both are eligible, go to the type opposite to last_was_write.
  - last_was_write resets to 0, so writes win the first tie.
- Write accept:
  - awready and wready pulse together for one cycle.
  - Latch the address as [ADDR_W-1:2]; low two bits are ignored. Latch wdata and wstrb.
  - Go to WR_ISSUE.
  - AW without W, or W without AW: nothing is accepted; wait in IDLE.
- WR_ISSUE: cbus_en=1, cbus_wen=1, addr and din driven, for one cycle. Then WR_RESP.
- WR_RESP: bvalid held until bready, then IDLE.
- Read accept: arready pulses for one cycle; latch address; go to RD_ISSUE.
- RD_ISSUE: cbus_en=1, cbus_wen=0 for one cycle. Then RD_WAIT.
- RD_WAIT:
  - A 3-bit counter runs RD_LAT cycles.
  - On the last cycle, register cbus_dout into rdata.
  - Then RD_RESP.
- RD_RESP: rvalid held, rdata stable, until rready, then IDLE.
- cbus_addr and cbus_din hold their last values outside en cycles. cbus_wen=0 whenever cbus_en=0.
- Reset asserted mid-operation:
  - All state is cleared immediately and the FSM returns to IDLE.
  - A pending response is discarded. A strobe cut by reset is not reissued.

## Timing
- Reset values: all ready/valid outputs 0; cbus_en 0, cbus_wen 0, cbus_addr 0, cbus_din 0; rdata 0, bresp 00, rresp 00; FSM IDLE; last_was_write 0.
- Write (handshake cycle T): cbus_en high at T+1, bvalid high from T+2.
- Read (handshake cycle T): cbus_en high at T+1, rdata captured at the end of T+1+RD_LAT, rvalid high from T+2+RD_LAT.
- Back-to-back: the earliest next handshake is the cycle after the bready/rready handshake. Maximum write throughput is 1 transaction per 3 cycles.
- Ready signals are never asserted outside IDLE.
- Valid outputs never drop without their handshake.

## Configuration
- CBUS_STRB_CHECK_EN defined:
  - A write with wstrb ≠ 4'hF issues no CBus strobe (cbus_en stays 0 in WR_ISSUE).
  - The write returns bresp=10 (SLVERR).
- Not defined: wstrb is ignored, the full word is written, and bresp=00.

## Test plan
- Write 0x0000_0104 ← 0xDEADBEEF, wstrb F, bready high:
  - Expect a single cbus_en/wen pulse at T+1 with cbus_addr=0x00041 and cbus_din=0xDEADBEEF.
  - Expect bvalid at T+2 with bresp=00.
- Read 0x0000_0208, RD_LAT=1, with cbus_dout forced to 0x12345678 at T+2:
  - Expect cbus_en with wen=0 at T+1.
  - Expect rvalid at T+3 with rdata=0x12345678.
- AW/W and AR valid in the same cycle, twice after reset:
  - Expect the write served first, then the read.
  - Exactly one cbus_en per transaction.
- Backpressure: hold rready low for 5 cycles.
  - rvalid and rdata stay stable.
  - arready stays 0 despite arvalid high.
  - Exactly one cbus_en for the read.
- wstrb=4'h3:
  - With CBUS_STRB_CHECK_EN, no cbus_en and bresp=10.
  - Without it, cbus_en pulses and bresp=00.
- Deassert rst_n during RD_WAIT:
  - All outputs return to reset values asynchronously.
  - No rvalid follows.
  - A fresh read after reset completes normally.

Source files
------------

// File: rtl/axi_lite_cbus_bridge_if.sv
// ============================================================================
// Module   : axi_lite_cbus_bridge_if
// Brief    : AXI4-Lite slave port plus CBus strobe bus of the CBus bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_lite_cbus_bridge_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic              cbus_en;
    logic              cbus_wen;
    logic [ADDR_W-3:0] cbus_addr;
    logic [31:0]       cbus_din;
    logic [31:0]       cbus_dout;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, cbus_dout,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output cbus_en, cbus_wen, cbus_addr, cbus_din
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, cbus_dout,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  cbus_en, cbus_wen, cbus_addr, cbus_din
    );
endinterface

`default_nettype wire

// File: rtl/axi_lite_cbus_bridge.sv
// ============================================================================
// Module   : axi_lite_cbus_bridge
// Brief    : AXI4-Lite slave issuing single-cycle CBus strobes, one access in
//            flight. Optional macro CBUS_STRB_CHECK_EN rejects partial writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_cbus_bridge #(
    parameter int ADDR_W = 20,
    parameter int RD_LAT = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    axi_lite_cbus_bridge_if.slave bus_io
);
    localparam int         c_CW      = ADDR_W - 2;
    localparam logic [2:0] c_RD_LAST = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_WR_RESP  = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RD_RESP  = 3'd5
    } state_t;

    state_t            state_q;
    logic              last_wr_q;
    logic              awready_q;
    logic              wready_q;
    logic              arready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic              cbus_en_q;
    logic              cbus_wen_q;
    logic [c_CW-1:0]   cbus_addr_q;
    logic [31:0]       cbus_din_q;
    logic [2:0]        cnt_q;

    logic w_wr_elig;
    logic w_pick_wr;
    logic w_pick_rd;
    logic w_strb_err;
    logic w_unused;

    // Round-robin: on a tie the type not served last time wins.
    assign w_wr_elig = bus_io.s_axi_awvalid & bus_io.s_axi_wvalid;
    assign w_pick_wr = w_wr_elig & (~bus_io.s_axi_arvalid | ~last_wr_q);
    assign w_pick_rd = bus_io.s_axi_arvalid & ~w_pick_wr;

`ifdef CBUS_STRB_CHECK_EN
    assign w_strb_err = (bus_io.s_axi_wstrb != 4'hF);
`else
    assign w_strb_err = 1'b0;
`endif

    assign w_unused = ^{bus_io.s_axi_awaddr[1:0], bus_io.s_axi_araddr[1:0], bus_io.s_axi_wstrb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_wr_q   <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'h0;
            cbus_en_q   <= 1'b0;
            cbus_wen_q  <= 1'b0;
            cbus_addr_q <= '0;
            cbus_din_q  <= 32'h0;
            cnt_q       <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Ready is raised one cycle after the request is seen and the
                    // choice is committed; the handshake completes on that cycle.
                    if (awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (w_wr_elig) begin
                            last_wr_q <= 1'b1;
                            bresp_q   <= w_strb_err ? 2'b10 : 2'b00;
                            if (!w_strb_err) begin
                                cbus_en_q   <= 1'b1;
                                cbus_wen_q  <= 1'b1;
                                cbus_addr_q <= bus_io.s_axi_awaddr[ADDR_W-1:2];
                                cbus_din_q  <= bus_io.s_axi_wdata;
                            end
                            state_q <= S_WR_ISSUE;
                        end
                    end else if (arready_q) begin
                        arready_q <= 1'b0;
                        if (bus_io.s_axi_arvalid) begin
                            last_wr_q   <= 1'b0;
                            cbus_en_q   <= 1'b1;
                            cbus_wen_q  <= 1'b0;
                            cbus_addr_q <= bus_io.s_axi_araddr[ADDR_W-1:2];
                            state_q     <= S_RD_ISSUE;
                        end
                    end else begin
                        awready_q <= w_pick_wr;
                        wready_q  <= w_pick_wr;
                        arready_q <= w_pick_rd;
                    end
                end
                S_WR_ISSUE: begin
                    cbus_en_q  <= 1'b0;
                    cbus_wen_q <= 1'b0;
                    bvalid_q   <= 1'b1;
                    state_q    <= S_WR_RESP;
                end
                S_WR_RESP: begin
                    if (bus_io.s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= w_pick_wr;
                        wready_q  <= w_pick_wr;
                        arready_q <= w_pick_rd;
                        state_q   <= S_IDLE;
                    end
                end
                S_RD_ISSUE: begin
                    cbus_en_q <= 1'b0;
                    cnt_q     <= 3'd0;
                    state_q   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (cnt_q == c_RD_LAST) begin
                        rdata_q  <= bus_io.cbus_dout;
                        rvalid_q <= 1'b1;
                        state_q  <= S_RD_RESP;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_RD_RESP: begin
                    if (bus_io.s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        awready_q <= w_pick_wr;
                        wready_q  <= w_pick_wr;
                        arready_q <= w_pick_rd;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_io.s_axi_awready = awready_q;
    assign bus_io.s_axi_wready  = wready_q;
    assign bus_io.s_axi_arready = arready_q;
    assign bus_io.s_axi_bvalid  = bvalid_q;
    assign bus_io.s_axi_bresp   = bresp_q;
    assign bus_io.s_axi_rvalid  = rvalid_q;
    assign bus_io.s_axi_rdata   = rdata_q;
    assign bus_io.s_axi_rresp   = 2'b00;
    assign bus_io.cbus_en       = cbus_en_q;
    assign bus_io.cbus_wen      = cbus_wen_q;
    assign bus_io.cbus_addr     = cbus_addr_q;
    assign bus_io.cbus_din      = cbus_din_q;
endmodule

`default_nettype wire

// File: tb/tb_axi_lite_cbus_bridge.sv
// ============================================================================
// Module   : tb_axi_lite_cbus_bridge
// Brief    : Scoreboard bench for axi_lite_cbus_bridge (honours CBUS_STRB_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_cbus_bridge;
    localparam int ADDR_W = 20;
    localparam int RD_LAT = 1;

    typedef struct {
        logic        wen;
        logic [17:0] addr;
        logic [31:0] din;
        int          cyc;
    } strobe_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          cyc;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    strobe_t sq[$];
    resp_t   bq[$];
    resp_t   rq[$];
    logic [31:0] model_mem [logic [17:0]];
    logic [31:0] periph_mem [logic [17:0]];
    bit   model_last = 1'b0;
    bit   bready_force = 1'b0;
    bit   bp_hold = 1'b0;
    bit   force_en = 1'b0;
    logic [31:0] force_val = 32'h0;

    axi_lite_cbus_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    axi_lite_cbus_bridge #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(input logic [17:0] w);
        return {w[13:0], w} ^ 32'h3C5A_0000;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    task automatic chk_reset();
        chk("rst_ctrl", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready, bus.s_axi_bvalid,
                         bus.s_axi_bresp, bus.s_axi_rvalid, bus.s_axi_rresp, bus.cbus_en, bus.cbus_wen}, 0);
        chk("rst_data", {bus.s_axi_rdata, bus.cbus_addr, bus.cbus_din}, 0);
    endtask

    // Host handshake drivers: expectations are pushed when the handshake is seen.
    task automatic wr_txn(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s, output int t);
        bit ok;
        @(posedge clk); #1;
        bus.s_axi_awaddr = a; bus.s_axi_wdata = d; bus.s_axi_wstrb = s;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.s_axi_awready && bus.s_axi_wready) begin t = cyc; break; end
        end
        if (t < 0) fail_now("aw_handshake_timeout");
        else begin
`ifdef CBUS_STRB_CHECK_EN
            ok = (s == 4'hF);
`else
            ok = 1'b1;
`endif
            if (ok) begin
                sq.push_back('{1'b1, a[19:2], d, t + 1});
                model_mem[a[19:2]] = d;
            end
            bq.push_back('{32'h0, ok ? 2'b00 : 2'b10, t + 2});
            model_last = 1'b1;
        end
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic rd_txn(input logic [19:0] a, input bit ovr, input logic [31:0] ovr_d, output int t);
        logic [31:0] e;
        @(posedge clk); #1;
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.s_axi_arready) begin t = cyc; break; end
        end
        if (t < 0) fail_now("ar_handshake_timeout");
        else begin
            e = ovr ? ovr_d : (model_mem.exists(a[19:2]) ? model_mem[a[19:2]] : dflt(a[19:2]));
            sq.push_back('{1'b0, a[19:2], 32'h0, t + 1});
            rq.push_back('{e, 2'b00, t + 2 + RD_LAT});
            model_last = 1'b0;
        end
        @(posedge clk); #1;
        bus.s_axi_arvalid = 1'b0;
    endtask

    task automatic tie_txn(input logic [19:0] wa, input logic [31:0] wd, input logic [19:0] ra);
        bit exp_wfirst;
        int tw, tr;
        exp_wfirst = !model_last;
        fork
            wr_txn(wa, wd, 4'hF, tw);
            rd_txn(ra, 1'b0, 32'h0, tr);
        join
        chk("tie_write_first", (tw < tr), exp_wfirst);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sq.size() + bq.size() + rq.size()) != 0 || bus.s_axi_bvalid || bus.s_axi_rvalid) begin
            @(negedge clk);
            n++;
            if (n > 300) begin fail_now("idle_timeout"); break; end
        end
    endtask

    // Response handshakes driven just after the active edge.
    initial begin
        int low_cnt = 0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.s_axi_bready = bready_force | ($urandom_range(0, 3) != 0);
            if (!bp_hold) low_cnt = 0;
            if (bp_hold && bus.s_axi_rvalid && low_cnt < 5) begin
                bus.s_axi_rready = 1'b0;
                low_cnt++;
            end else begin
                bus.s_axi_rready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Peripheral register block: read data valid only RD_LAT cycles after the strobe.
    initial begin
        int          pend_cyc = -1;
        logic [17:0] pend_addr = '0;
        bus.cbus_dout = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) pend_cyc = -1;
            else begin
                if (bus.cbus_en && bus.cbus_wen) periph_mem[bus.cbus_addr] = bus.cbus_din;
                if (bus.cbus_en && !bus.cbus_wen) begin
                    pend_addr = bus.cbus_addr;
                    pend_cyc  = cyc + RD_LAT;
                end
            end
            if (cyc == pend_cyc)
                bus.cbus_dout = force_en ? force_val :
                                (periph_mem.exists(pend_addr) ? periph_mem[pend_addr] : dflt(pend_addr));
            else
                bus.cbus_dout = $urandom;
        end
    end

    // Monitor / scoreboard.
    initial begin
        strobe_t     se;
        resp_t       re;
        bit          pbv = 1'b0, pbr = 1'b0, prv = 1'b0, prr = 1'b0;
        logic [1:0]  pbresp = 2'b00;
        logic [31:0] prdata = 32'h0;
        int          brise = 0, rrise = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sq.delete(); bq.delete(); rq.delete();
                pbv = 1'b0; prv = 1'b0;
            end else begin
                if (bus.cbus_en) begin
                    if (sq.size() == 0) fail_now("cbus_en_unexpected");
                    else begin
                        se = sq.pop_front();
                        chk("cbus_strobe", {bus.cbus_wen, bus.cbus_addr, bus.cbus_wen ? bus.cbus_din : 32'h0},
                            {se.wen, se.addr, se.wen ? se.din : 32'h0});
                        chk("cbus_cycle", cyc, se.cyc);
                    end
                end else chk("cbus_wen_idle", bus.cbus_wen, 1'b0);
                if (bus.cbus_en || bus.s_axi_bvalid || bus.s_axi_rvalid)
                    chk("ready_while_busy", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b000);
                chk("aw_w_ready_pair", bus.s_axi_awready, bus.s_axi_wready);

                if (bus.s_axi_bvalid && !pbv) brise = cyc;
                if (pbv && !pbr) chk("b_hold", {bus.s_axi_bvalid, bus.s_axi_bresp}, {1'b1, pbresp});
                if (bus.s_axi_bvalid && bus.s_axi_bready) begin
                    if (bq.size() == 0) fail_now("bvalid_unexpected");
                    else begin
                        re = bq.pop_front();
                        chk("bresp", bus.s_axi_bresp, re.resp);
                        chk("bvalid_cycle", brise, re.cyc);
                    end
                end

                if (bus.s_axi_rvalid && !prv) rrise = cyc;
                if (prv && !prr) chk("r_hold", {bus.s_axi_rvalid, bus.s_axi_rdata}, {1'b1, prdata});
                if (bus.s_axi_rvalid && bus.s_axi_rready) begin
                    if (rq.size() == 0) fail_now("rvalid_unexpected");
                    else begin
                        re = rq.pop_front();
                        chk("rdata", {bus.s_axi_rresp, bus.s_axi_rdata}, {re.resp, re.data});
                        chk("rvalid_cycle", rrise, re.cyc);
                    end
                end
                pbv = bus.s_axi_bvalid; pbr = bus.s_axi_bready; pbresp = bus.s_axi_bresp;
                prv = bus.s_axi_rvalid; prr = bus.s_axi_rready; prdata = bus.s_axi_rdata;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1);
    end

    initial begin
        int t, t2;
        bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0;
        bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        rst_n = 1'b1;

        bready_force = 1'b1;
        wr_txn(20'h00104, 32'hDEADBEEF, 4'hF, t);
        wait_idle();
        bready_force = 1'b0;

        force_en = 1'b1; force_val = 32'h12345678;
        rd_txn(20'h00208, 1'b1, 32'h12345678, t);
        wait_idle();
        force_en = 1'b0;

        @(negedge clk); rst_n = 1'b0; model_last = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tie_txn(20'h00010, 32'hA5A5_0001, 20'h00010);
        wait_idle();
        tie_txn(20'h00014, 32'h5A5A_0002, 20'h00018);
        wait_idle();

        bp_hold = 1'b1;
        rd_txn(20'h00104, 1'b0, 32'h0, t);
        rd_txn(20'h00010, 1'b0, 32'h0, t2);
        wait_idle();
        bp_hold = 1'b0;

        wr_txn(20'h00020, 32'hCAFE_F00D, 4'h3, t);
        wait_idle();
        rd_txn(20'h00020, 1'b0, 32'h0, t);
        wait_idle();

        for (int i = 0; i < 80; i++) begin
            logic [19:0] a, b;
            logic [31:0] d;
            logic [3:0]  s;
            a = (20'($urandom_range(0, 15)) << 2) | 20'($urandom_range(0, 3)) |
                (($urandom_range(0, 1) == 1) ? 20'h40000 : 20'h0);
            b = (20'($urandom_range(0, 15)) << 2) | 20'($urandom_range(0, 3));
            d = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case ($urandom_range(0, 4))
                0, 1:    wr_txn(a, d, s, t);
                2, 3:    rd_txn(a, 1'b0, 32'h0, t);
                default: tie_txn(a, d, b);
            endcase
            wait_idle();
        end

        rd_txn(20'h00030, 1'b0, 32'h0, t);
        for (int i = 0; i < 10 && cyc < t + 2; i++) @(negedge clk);
        rst_n = 1'b0;
        model_last = 1'b0;
        #1;
        chk_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("no_rvalid_after_reset", bus.s_axi_rvalid, 1'b0);
        end
        rd_txn(20'h00030, 1'b0, 32'h0, t);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

`default_nettype wire
